// File: rtl/max_pool_pkg.sv
// Shared definitions for the max-pooling datapath: default geometry, the argmax
// index encoding used by both the pooling and unpooling blocks, and FSM states.
package max_pool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_KERNEL_DIM = 3;
    localparam int WINDOW_SIZE        = DEFAULT_KERNEL_DIM * DEFAULT_KERNEL_DIM;
    localparam int INDEX_WIDTH        = $clog2(WINDOW_SIZE);

    // Row-major argmax position inside a pooling window.
    typedef logic [INDEX_WIDTH-1:0] argmaxIndexT;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpoolStateT;

endpackage

// File: rtl/max_unpool.sv
// Streaming max-unpooling: expands each (value, argmax) token into a full
// KERNEL_DIM x KERNEL_DIM window of serial pixels, zero everywhere but the argmax.
module max_unpool
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_DIM   = DEFAULT_KERNEL_DIM,
    localparam int WIN_SIZE    = KERNEL_DIM * KERNEL_DIM,
    localparam int IDX_WIDTH   = $clog2(WIN_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inPixel,
    input  logic [IDX_WIDTH-1:0]  inIndex,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outPixel,
    output logic                  outLast,
    output logic                  indexError
);

    localparam logic [IDX_WIDTH-1:0] LAST_BEAT = IDX_WIDTH'(WIN_SIZE - 1);

    unpoolStateT           stateQ, stateD;
    logic [DATA_WIDTH-1:0] valueQ, valueD;
    logic [IDX_WIDTH-1:0]  indexQ, indexD;
    logic [IDX_WIDTH-1:0]  beatQ, beatD;
    logic                  errQ, errD;
    logic                  lastBeat;
    logic                  accept;

    always_comb begin
        lastBeat = (beatQ == LAST_BEAT);
        outValid = (stateQ == EMIT);
        outLast  = outValid && lastBeat;
        // Ready also opens on the final beat so consecutive windows have no bubble.
        inReady  = !rst && ((stateQ == IDLE) || (outLast && outReady));
        outPixel = (outValid && (beatQ == indexQ)) ? valueQ : '0;
        accept   = inValid && inReady;
    end

    always_comb begin
        stateD = stateQ;
        valueD = valueQ;
        indexD = indexQ;
        beatD  = beatQ;
        errD   = errQ;
        if (accept) begin
            stateD = EMIT;
            valueD = inPixel;
            indexD = inIndex;
            beatD  = '0;
            // Out-of-range index never matches a beat, so the window emits zeros.
            if (inIndex > LAST_BEAT) begin
                errD = 1'b1;
            end
        end else if (outValid && outReady) begin
            if (lastBeat) begin
                stateD = IDLE;
                beatD  = '0;
            end else begin
                beatD = beatQ + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            valueQ <= '0;
            indexQ <= '0;
            beatQ  <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            valueQ <= valueD;
            indexQ <= indexD;
            beatQ  <= beatD;
            errQ   <= errD;
        end
    end

    assign indexError = errQ;

endmodule
